seg_scan_decoder: RTL and testbench

Monitor/decoder for the multiplexed 8-digit common-anode seven-segment bus that our display drivers emit. The block samples the active-low `seg` and `sel` lines and waits for each digit slot to settle. It then decodes each segment pattern back to a 4-bit digit value and assembles a full 8-digit snapshot. It sits in self-test and loopback paths, so display content can be checked in hardware without a camera or probe.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg7_pattern_decode.sv | 42 ++++
 rtl/seg_scan_decoder.sv | 117 +++++++++++
 tb/tb_seg_scan_decoder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns (bit order g..a), digit count and FSM state encoding.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational pattern -> digit lookup. Hex letters A..F are recognised only
// when SEG_DEC_HEX_EN is defined; otherwise they fall into the unknown set.
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       known,
  output logic       blank,
  output logic [3:0] value
);

  // known covers both digits and the blank pattern; blank flags the latter
  always_comb begin
    known = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (pattern)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
`ifdef SEG_DEC_HEX_EN
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
`else
`endif
      SEG_BLANK: blank = 1'b1;
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 8-digit active-low seven-segment bus into a digit
// snapshot. Hex decode is enabled by SEG_DEC_HEX_EN (in seg7_pattern_decode).
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [7:0]  sel,
  output logic [31:0] digits_o,
  output logic [7:0]  dp_o,
  output logic [7:0]  valid_o,
  output logic        frame_done,
  output logic        err
);

  localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

  logic [15:0] sync1, sync2, prev;
  logic [1:0]  fill;
  logic [7:0]  cnt, sel_n, mask;
  logic        chg, capture, sel_blank, sel_one;
  logic        known, blank;
  logic [3:0]  value;
  state_t      state, state_nxt;

  // fill masks the pseudo-change as the reset value of the synchronizer drains,
  // so a value held across reset is never treated as fresh
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      fill  <= 2'd0;
      cnt   <= 8'd0;
      state <= ST_IDLE;
    end else begin
      sync1 <= {seg, sel};
      sync2 <= sync1;
      prev  <= sync2;
      if (fill != 2'd3) fill <= fill + 2'd1;
      if (sync2 != prev)     cnt <= 8'd0;
      else if (cnt != 8'hFF) cnt <= cnt + 8'd1;
      state <= state_nxt;
    end
  end

  assign chg       = (sync2 != prev) && (fill == 2'd3);
  assign sel_n     = ~sync2[7:0];
  assign sel_blank = (sel_n == 8'd0);
  assign sel_one   = !sel_blank && ((sel_n & (sel_n - 8'd1)) == 8'd0);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE:   if (chg) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!chg && cnt == CAP_CNT) begin
          state_nxt = ST_HELD;
          capture   = 1'b1;
        end
      end
      ST_HELD:   if (chg) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  seg7_pattern_decode u_dec (
    .pattern (sync2[14:8]),
    .known   (known),
    .blank   (blank),
    .value   (value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_o   <= 32'd0;
      dp_o       <= 8'd0;
      valid_o    <= 8'd0;
      mask       <= 8'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      err        <= 1'b0;
      frame_done <= 1'b0;
      if (capture && !sel_blank) begin
        if (!sel_one || !known) err <= 1'b1;
        if (sel_one) begin
          for (int n = 0; n < NUM_DIGITS; n++) begin
            if (sel_n[n]) begin
              if (known) begin
                digits_o[4*n +: 4] <= blank ? 4'h0 : value;
                dp_o[n]            <= ~sync2[15];
                valid_o[n]         <= ~blank;
              end else begin
                valid_o[n]         <= 1'b0;
              end
            end
          end
          // completing capture closes the frame; mask restarts empty
          if (known) begin
            if ((mask | sel_n) == 8'hFF) begin
              frame_done <= 1'b1;
              mask       <= 8'd0;
            end else begin
              mask       <= mask | sel_n;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: window-based reference model checked every cycle,
// plus directed scans with literal expectations.
module tb_seg_scan_decoder;

  localparam int S = 4;
`ifdef SEG_DEC_HEX_EN
  localparam int NPAT = 16;
`else
  localparam int NPAT = 10;
`endif
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                      7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                      7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg, sel;
  logic [31:0] digits_o;
  logic [7:0]  dp_o, valid_o;
  logic        frame_done, err;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .sel        (sel),
    .digits_o   (digits_o),
    .dp_o       (dp_o),
    .valid_o    (valid_o),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int fd_cnt = 0, err_cnt = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A sample is captured once it has been seen on S+1 consecutive edges after a
  // real change (both sides of the change sampled after reset); the effect
  // appears two edges later, when the synchronized copy has held that long.
  logic [15:0] hist [0:8191];
  int          np;
  logic [31:0] e_dig;
  logic [7:0]  e_dp, e_val, e_mask;
  logic        e_fd, e_err;
  int          b;
  bit          ok;

  function automatic void model_capture(input logic [15:0] v);
    logic [7:0] sg, sl;
    int n, idx;
    sg = v[15:8];
    sl = v[7:0];
    if (sl == 8'hFF) return;
    if ($countones(~sl) != 1) begin e_err = 1'b1; return; end
    n = 0;
    for (int i = 0; i < 8; i++) if (!sl[i]) n = i;
    idx = -1;
    for (int d = 0; d < NPAT; d++) if (PAT[d] == sg[6:0]) idx = d;
    if (idx >= 0) begin
      e_dig[4*n +: 4] = idx[3:0];
      e_val[n] = 1'b1;
      e_dp[n]  = ~sg[7];
    end else if (sg[6:0] == 7'h7F) begin
      e_dig[4*n +: 4] = 4'h0;
      e_val[n] = 1'b0;
      e_dp[n]  = ~sg[7];
    end else begin
      e_err = 1'b1;
      e_val[n] = 1'b0;
      return;
    end
    e_mask[n] = 1'b1;
    if (e_mask == 8'hFF) begin
      e_fd = 1'b1;
      e_mask = 8'h00;
    end
  endfunction

  always @(posedge clk) begin
    e_fd = 1'b0;
    e_err = 1'b0;
    if (!rst_n) begin
      np = 0;
      e_dig = 32'd0; e_dp = 8'd0; e_val = 8'd0; e_mask = 8'd0;
    end else begin
      np++;
      hist[np] = {seg, sel};
      b = np - 2 - S;
      if (b >= 2 && hist[b] != hist[b-1]) begin
        ok = 1'b1;
        for (int k = b + 1; k <= np - 2; k++) if (hist[k] != hist[b]) ok = 1'b0;
        if (ok) model_capture(hist[b]);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1 started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("digits_o", digits_o, e_dig);
      chk("dp_o", {24'd0, dp_o}, {24'd0, e_dp});
      chk("valid_o", {24'd0, valid_o}, {24'd0, e_val});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      chk("err", {31'd0, err}, {31'd0, e_err});
      fd_cnt  += int'(frame_done);
      err_cnt += int'(err);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [7:0] s, input logic [7:0] l, input int n);
    seg = s;
    sel = l;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] dsel(input int n);
    logic [7:0] one;
    one = 8'd1 << n;
    return ~one;
  endfunction

  function automatic logic [7:0] dseg(input int v);
    return {1'b1, PAT[v]};
  endfunction

  logic [47:0] snap;
  int f0, e0;

  initial begin
    rst_n = 1'b0;
    seg = 8'hFF;
    sel = 8'hFF;
    repeat (3) @(negedge clk);
    #2;
    chk("reset digits", digits_o, 32'd0);
    chk("reset valid", {24'd0, valid_o}, 32'd0);
    chk("reset dp", {24'd0, dp_o}, 32'd0);
    rst_n = 1'b1;
    hold(8'hFF, 8'hFF, 5);

    // full scan "12345678" with a latency probe on the first digit
    f0 = fd_cnt; e0 = err_cnt;
    hold(dseg(1), dsel(0), S + 2);
    #2;
    chk("latency early", {28'd0, digits_o[3:0]}, 32'd0);
    hold(dseg(1), dsel(0), 1);
    #2;
    chk("latency on time", {28'd0, digits_o[3:0]}, 32'd1);
    chk("latency valid", {31'd0, valid_o[0]}, 32'd1);
    hold(dseg(1), dsel(0), 20 - (S + 3));
    for (int n = 1; n < 8; n++) hold(dseg(n + 1), dsel(n), 20);
    #2;
    chk("scan digits", digits_o, 32'h87654321);
    chk("scan valid", {24'd0, valid_o}, 32'hFF);
    chk("scan frame_done count", fd_cnt - f0, 1);
    chk("scan err count", err_cnt - e0, 0);
    hold(8'hFF, 8'hFF, 10);

    // decimal point, blank with dp, blank without dp on digit 3
    e0 = err_cnt;
    hold(8'h78, 8'hF7, 20);
    #2;
    chk("dp digit3", {31'd0, dp_o[3]}, 32'd1);
    chk("dp value3", {28'd0, digits_o[15:12]}, 32'd7);
    chk("dp valid3", {31'd0, valid_o[3]}, 32'd1);
    hold(8'h7F, 8'hF7, 20);
    #2;
    chk("blank dp valid3", {31'd0, valid_o[3]}, 32'd0);
    chk("blank dp value3", {28'd0, digits_o[15:12]}, 32'd0);
    chk("blank dp dp3", {31'd0, dp_o[3]}, 32'd1);
    hold(8'hFF, 8'hF7, 20);
    #2;
    chk("blank valid3", {31'd0, valid_o[3]}, 32'd0);
    chk("blank dp3 off", {31'd0, dp_o[3]}, 32'd0);
    chk("blank err count", err_cnt - e0, 0);

    // two selects active at once
    snap = {digits_o, dp_o, valid_o};
    e0 = err_cnt;
    hold(dseg(5), 8'hFC, 10);
    #2;
    chk("illegal sel err count", err_cnt - e0, 1);
    chk("illegal sel outputs hi", snap[47:16], digits_o);
    chk("illegal sel outputs lo", {16'd0, snap[15:0]}, {16'd0, dp_o, valid_o});
    hold(8'hFF, 8'hFF, 10);

    // glitchy segments never settle long enough
    snap = {digits_o, dp_o, valid_o};
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      hold(dseg(3), 8'hFE, 3);
      hold(dseg(9), 8'hFE, 3);
    end
    #2;
    chk("glitch outputs hi", snap[47:16], digits_o);
    chk("glitch outputs lo", {16'd0, snap[15:0]}, {16'd0, dp_o, valid_o});
    chk("glitch err count", err_cnt - e0, 0);
    hold(8'hFF, 8'hFF, 10);

    // hex letter A on digit 0
    e0 = err_cnt;
    hold(8'h88, 8'hFE, 20);
    #2;
`ifdef SEG_DEC_HEX_EN
    chk("hex value0", {28'd0, digits_o[3:0]}, 32'hA);
    chk("hex valid0", {31'd0, valid_o[0]}, 32'd1);
    chk("hex err count", err_cnt - e0, 0);
`else
    chk("hex err count", err_cnt - e0, 1);
    chk("hex valid0", {31'd0, valid_o[0]}, 32'd0);
`endif
    hold(8'hFF, 8'hFF, 10);

    // reset mid-frame, held value must not be captured afterwards
    for (int n = 0; n < 5; n++) hold(dseg(9 - n), dsel(n), 20);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("midrst digits", digits_o, 32'd0);
    chk("midrst valid", {24'd0, valid_o}, 32'd0);
    chk("midrst dp", {24'd0, dp_o}, 32'd0);
    chk("midrst pulses", {30'd0, frame_done, err}, 32'd0);
    rst_n = 1'b1;
    hold(dseg(5), dsel(4), 12);
    #2;
    chk("post rst no capture", {24'd0, valid_o}, 32'd0);
    f0 = fd_cnt;
    for (int n = 0; n < 7; n++) hold(dseg(n + 1), dsel(n), 20);
    #2;
    chk("post rst partial frame", fd_cnt - f0, 0);
    hold(dseg(8), dsel(7), 20);
    #2;
    chk("post rst frame_done", fd_cnt - f0, 1);
    chk("post rst digits", digits_o, 32'h87654321);
    chk("post rst valid", {24'd0, valid_o}, 32'hFF);
    hold(8'hFF, 8'hFF, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
